// File: rtl/shufflenetv2_mul_arbiter.sv
// rtl/shufflenetv2_mul_arbiter.sv - round-robin arbiter sharing one pipelined unsigned multiplier
//
// Purpose: NUM_REQ requesters offer (a, b) operand pairs; a round-robin arbiter
// grants one per cycle into a MUL_STAGES-deep multiplier pipeline whose last
// stage presents the product together with the owning requester index.
//
// Ports:
//   ap_clk     - clock, all state on rising edge
//   ap_rst     - synchronous active-high reset
//   req_valid  - per-requester operand valid
//   req_ready  - per-requester accept (one-hot or zero)
//   req_a      - operand A, requester i in slice i
//   req_b      - operand B, requester i in slice i
//   rsp_valid  - product valid
//   rsp_ready  - downstream accepts product
//   rsp_id     - index of requester owning rsp_p
//   rsp_p      - unsigned product A*B
//   busy       - any pipeline stage holds a valid operation
module shufflenetv2_mul_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int A_WIDTH    = 12,
  parameter int B_WIDTH    = 10,
  parameter int P_WIDTH    = 22,
  parameter int MUL_STAGES = 3,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [P_WIDTH-1:0]           rsp_p,
  output logic                         busy
);

  logic [MUL_STAGES-1:0] stg_valid;
  logic [ID_W-1:0]       stg_id [MUL_STAGES];
  logic [P_WIDTH-1:0]    stg_p  [MUL_STAGES];

  logic [ID_W-1:0]    ptr;
  logic               advance;
  logic               grant_any;
  logic [ID_W-1:0]    grant_idx;
  logic               transfer;
  logic [A_WIDTH-1:0] sel_a;
  logic [B_WIDTH-1:0] sel_b;
  logic [P_WIDTH-1:0] product;

  // The whole pipeline moves as one; a stalled output freezes every stage.
  assign advance = !rsp_valid || rsp_ready;

  // First set request at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin : arb
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  // Grants are suppressed during reset so nothing is accepted then.
  assign transfer = advance && grant_any && !ap_rst;

  always_comb begin
    req_ready = '0;
    if (transfer) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign sel_a   = req_a[grant_idx*A_WIDTH +: A_WIDTH];
  assign sel_b   = req_b[grant_idx*B_WIDTH +: B_WIDTH];
  // Operands widened to the product width first so nothing is truncated.
  assign product = P_WIDTH'(sel_a) * P_WIDTH'(sel_b);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ptr       <= '0;
      stg_valid <= '0;
      for (int i = 0; i < MUL_STAGES; i++) begin
        stg_id[i] <= '0;
        stg_p[i]  <= '0;
      end
    end else if (advance) begin
      if (transfer) begin
        ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      // A non-transfer advancing cycle inserts a bubble into stage 1.
      stg_valid[0] <= transfer;
      stg_id[0]    <= grant_idx;
      stg_p[0]     <= product;
      for (int i = 1; i < MUL_STAGES; i++) begin
        stg_valid[i] <= stg_valid[i-1];
        stg_id[i]    <= stg_id[i-1];
        stg_p[i]     <= stg_p[i-1];
      end
    end
  end

  assign rsp_valid = stg_valid[MUL_STAGES-1];
  assign rsp_id    = stg_id[MUL_STAGES-1];
  assign rsp_p     = stg_p[MUL_STAGES-1];
  assign busy      = |stg_valid;

endmodule

// File: tb/tb_shufflenetv2_mul_arbiter.sv
// tb/tb_shufflenetv2_mul_arbiter.sv - scoreboard bench for shufflenetv2_mul_arbiter
module tb_shufflenetv2_mul_arbiter;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [47:0] req_a;
  logic [39:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [21:0] rsp_p;
  logic        busy;

  logic [11:0] a_op [4];
  logic [9:0]  b_op [4];

  typedef struct {
    int id;
    int p;
  } exp_t;
  exp_t exp_q [$];

  int errors = 0;
  int checks = 0;

  always #5 ap_clk = ~ap_clk;

  always_comb begin
    req_a = {a_op[3], a_op[2], a_op[1], a_op[0]};
    req_b = {b_op[3], b_op[2], b_op[1], b_op[0]};
  end

  shufflenetv2_mul_arbiter dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // Monitor: every accepted product is popped and compared in order.
  always @(negedge ap_clk) begin
    if (!ap_rst && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got id=%0d p=%0d, required no product", rsp_id, rsp_p);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (int'(rsp_id) != e.id || int'(rsp_p) != e.p) begin
          errors++;
          $display("FAIL rsp_data: got id=%0d p=%0d, required id=%0d p=%0d",
                   rsp_id, rsp_p, e.id, e.p);
        end
      end
    end
  end

  // One cycle: drive inputs after the edge, check grant mid-cycle, push expected.
  task automatic cycle(input logic [3:0] rv, input logic rr, input int exp_g);
    logic [3:0] want;
    @(posedge ap_clk);
    #1;
    ap_rst    = 1'b0;
    req_valid = rv;
    rsp_ready = rr;
    want = (exp_g < 0) ? 4'b0000 : 4'(1 << exp_g);
    @(negedge ap_clk);
    chk("req_ready", 32'(req_ready), 32'(want));
    if (exp_g >= 0) begin
      exp_t e;
      e.id = exp_g;
      e.p  = int'(a_op[exp_g]) * int'(b_op[exp_g]);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(posedge ap_clk);
    #1;
    ap_rst    = 1'b1;
    req_valid = 4'hf;
    rsp_ready = 1'b1;
    exp_q.delete();
    @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_p", 32'(rsp_p), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
  endtask

  task automatic drain_and_check(input string name);
    repeat (6) cycle(4'b0000, 1'b1, -1);
    chk(name, 32'(exp_q.size()), 0);
  endtask

  logic       bp_rr [12] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
  int         bp_g  [12] = '{0, 1, 2, 3, -1, -1, -1, -1, -1, 0, 1, 2};

  initial begin
    for (int i = 0; i < 4; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
    end
    a_op[0] = 12'd4095;
    b_op[0] = 10'd1023;
    do_reset();

    // Single request at maximum operands
    cycle(4'b0001, 1'b1, 0);
    cycle(4'b0000, 1'b1, -1);
    chk("single_busy_t1", 32'(busy), 1);
    cycle(4'b0000, 1'b1, -1);
    chk("single_valid_t2", 32'(rsp_valid), 0);
    cycle(4'b0000, 1'b1, -1);
    chk("single_valid_t3", 32'(rsp_valid), 1);
    chk("single_id_t3", 32'(rsp_id), 0);
    chk("single_p_t3", 32'(rsp_p), 32'd4189185);
    cycle(4'b0000, 1'b1, -1);
    chk("single_busy_t4", 32'(busy), 0);
    chk("single_valid_t4", 32'(rsp_valid), 0);

    // Fairness, with a transfer in the first cycle after reset
    for (int i = 0; i < 4; i++) begin
      a_op[i] = 12'(i + 1);
      b_op[i] = 10'd2;
    end
    do_reset();
    for (int k = 0; k < 6; k++) cycle(4'hf, 1'b1, k % 4);
    drain_and_check("fair_queue_empty");

    // Backpressure: five stalled cycles hold the id1 product
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cycle(4'hf, bp_rr[k], bp_g[k]);
      if (k >= 4 && k <= 8) begin
        chk("bp_hold_valid", 32'(rsp_valid), 1);
        chk("bp_hold_id", 32'(rsp_id), 1);
        chk("bp_hold_p", 32'(rsp_p), 4);
      end
    end
    drain_and_check("bp_queue_empty");

    // Reset mid-flight discards three accepted operations
    do_reset();
    cycle(4'b0111, 1'b1, 0);
    cycle(4'b0111, 1'b1, 1);
    cycle(4'b0111, 1'b1, 2);
    @(posedge ap_clk);
    #1;
    ap_rst    = 1'b1;
    req_valid = 4'hf;
    exp_q.delete();
    @(negedge ap_clk);
    chk("midrst_req_ready", 32'(req_ready), 0);
    cycle(4'b0000, 1'b1, -1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    repeat (5) cycle(4'b0000, 1'b1, -1);
    cycle(4'hf, 1'b1, 0);
    cycle(4'b0000, 1'b1, -1);

    // Sparse requests from ptr=1, zero operand
    a_op[0] = 12'd0;
    b_op[0] = 10'd1023;
    a_op[2] = 12'd7;
    b_op[2] = 10'd3;
    cycle(4'b0101, 1'b1, 2);
    cycle(4'b0101, 1'b1, 0);
    cycle(4'hf, 1'b1, 1);
    drain_and_check("sparse_queue_empty");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shufflenetv2_mul_arbiter.md
SHUFFLENETV2_MUL_ARBITER -- requirements
Module: shufflenetv2_mul_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter A_WIDTH, default 12: unsigned operand A width.
REQ-003 SHALL have parameter B_WIDTH, default 10: unsigned operand B width.
REQ-004 SHALL have parameter P_WIDTH, default 22: product width, equal to A_WIDTH+B_WIDTH.
REQ-005 SHALL have parameter MUL_STAGES, default 3: multiplier pipeline depth, 1..6.
REQ-006 SHALL have port ap_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port ap_rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port req_valid, input, NUM_REQ bits: per-requester operand valid.
REQ-009 SHALL have port req_ready, output, NUM_REQ bits: per-requester accept; at most one bit set.
REQ-010 SHALL have port req_a, input, NUM_REQ*A_WIDTH bits: operand A of requester i in slice i.
REQ-011 SHALL have port req_b, input, NUM_REQ*B_WIDTH bits: operand B of requester i in slice i.
REQ-012 SHALL have port rsp_valid, output, 1 bit: product valid.
REQ-013 SHALL have port rsp_ready, input, 1 bit: downstream accepts product.
REQ-014 SHALL have port rsp_id, output, clog2(NUM_REQ) bits: index of the requester that owns rsp_p.
REQ-015 SHALL have port rsp_p, output, P_WIDTH bits: unsigned product A*B.
REQ-016 SHALL have port busy, output, 1 bit: high while any operation is in flight.

Function
REQ-017 SHALL share one unsigned A_WIDTH x B_WIDTH multiplier among all requesters; the multiplier has MUL_STAGES register stages, the last driving rsp_p/rsp_id/rsp_valid.
REQ-018 SHALL define advance = !rsp_valid || rsp_ready; when advance is low, every pipeline stage and the round-robin pointer SHALL hold.
REQ-019 SHALL assert req_ready[g] combinationally only when advance is high and g is the round-robin winner among the set req_valid bits; a transfer occurs when req_valid[g] and req_ready[g] are both high.
REQ-020 SHALL choose the winner as the first set req_valid bit at or after pointer ptr, scanning upward modulo NUM_REQ.
REQ-021 SHALL update ptr to (g+1) mod NUM_REQ on each transfer, and leave ptr unchanged on cycles with no transfer.
REQ-022 SHALL present the product of a transfer accepted in cycle T as rsp_valid=1 in cycle T+MUL_STAGES when there are no stalls; each stall cycle adds one cycle.
REQ-023 SHALL hold rsp_valid, rsp_id and rsp_p stable while rsp_valid=1 and rsp_ready=0.
REQ-024 SHALL insert a bubble (valid=0) into stage 1 on any advancing cycle without a transfer; rsp_p and rsp_id are don't-care when rsp_valid=0.
REQ-025 SHALL compute the product exactly, with no truncation; maximum 4095*1023 = 4189185 at the default widths.
REQ-026 SHALL sustain one transfer per cycle when rsp_ready is held high, and deliver products in acceptance order.
REQ-027 SHALL drive busy high when any stage valid bit is set, including the output stage.
REQ-028 SHALL leave a requester's req_valid with no effect unless it wins; a requester that drops req_valid before winning loses nothing.

Reset
REQ-029 SHALL, while ap_rst=1, clear every stage valid bit and set ptr=0, rsp_valid=0, rsp_id=0, rsp_p=0, busy=0, and req_ready=0.
REQ-030 SHALL discard all in-flight operations on a reset asserted mid-operation; no product of a pre-reset transfer appears afterwards.
REQ-031 SHALL allow a transfer in the first cycle after ap_rst deasserts.

Verification
REQ-032 Single request: req_valid=0001, a=4095, b=1023, rsp_ready=1 -> req_ready=0001 at T; rsp_valid=1, rsp_id=0, rsp_p=4189185 at T+3; busy=0 at T+4.
REQ-033 Fairness: req_valid=1111 held high, rsp_ready=1, requester i supplies a=i+1, b=2 -> grants 0,1,2,3,0,1 on consecutive cycles; rsp_id sequence 0,1,2,3,... with rsp_p 2,4,6,8.
REQ-034 Backpressure: the stream of REQ-033 with rsp_ready=0 for 5 cycles once rsp_valid=1 -> rsp outputs frozen, req_ready=0000, ptr unchanged; on release the stream resumes with no loss or duplicate.
REQ-035 Sparse or skip: req_valid=0101 from ptr=1 -> grant 2 then 0; ptr ends at 1; a=0, b=1023 gives rsp_p=0.
REQ-036 Reset mid-flight: 3 transfers accepted, ap_rst=1 for 1 cycle in the next cycle -> rsp_valid=0 and busy=0 after reset, ptr=0, and none of the 3 products is emitted.
